// File: rtl/md_sched.sv
// HI/LO multiply/divide scheduler: sequences mult/div over fixed cycle counts and stalls D-stage HI/LO ops.
// Optional madd/maddu/msub/msubu support is enabled by defining MD_MADD_EN.
module md_sched #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        mul_start, div_start;
  logic [63:0] prod_s, prod_u, mul_res;
  logic        div_signed;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

`ifdef MD_MADD_EN
  assign mul_start = (op == OP_MULT) || (op == OP_MULTU) || ((op >= OP_MADD) && (op <= OP_MSUBU));
`else
  assign mul_start = (op == OP_MULT) || (op == OP_MULTU);
`endif
  assign div_start = (op == OP_DIV) || (op == OP_DIVU);

  // Sign-extending to 64 bits lets one unsigned multiplier produce the exact signed product.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  always_comb begin
    mul_res = prod_s;
    case (op_q)
      OP_MULTU: mul_res = prod_u;
`ifdef MD_MADD_EN
      OP_MADD:  mul_res = {hi_q, lo_q} + prod_s;
      OP_MADDU: mul_res = {hi_q, lo_q} + prod_u;
      OP_MSUB:  mul_res = {hi_q, lo_q} - prod_s;
      OP_MSUBU: mul_res = {hi_q, lo_q} - prod_u;
`endif
      default:  mul_res = prod_s;
    endcase
  end

  // Magnitude divide avoids the INT_MIN / -1 overflow; negating 0x80000000 wraps to itself.
  assign div_signed = (op_q == OP_DIV);
  assign a_mag = (div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
  assign b_mag = (div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
  assign quo   = (div_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - q_mag) : q_mag;
  assign rem   = (div_signed && a_q[31]) ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (mul_start) begin
          a_d = a; b_d = b; op_d = op; cnt_d = MUL_N; state_d = MUL;
        end else if (div_start) begin
          a_d = a; b_d = b; op_d = op; cnt_d = DIV_N; state_d = DIV;
        end else if (op == OP_MTHI) begin
          hi_d = a;
        end else if (op == OP_MTLO) begin
          lo_d = a;
        end
      end
      MUL: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          {hi_d, lo_d} = mul_res;
          state_d      = IDLE;
        end
      end
      DIV: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign stall = d_md && (busy || mul_start || div_start);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched; expected values are hand-computed.
// Define MD_MADD_EN for both bench and RTL to exercise the accumulate ops.
module tb_md_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  md_sched dut (
    .clk   (clk),
    .rst   (rst),
    .op    (op),
    .a     (a),
    .b     (b),
    .d_md  (d_md),
    .busy  (busy),
    .stall (stall),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] av,
                               input logic [31:0] bv, input logic dm);
    op   = o;
    a    = av;
    b    = bv;
    d_md = dm;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts busy cycles (bounded) while checking stall each cycle, then checks the length.
  task automatic waitBusy(input string tag, input int expN, input logic expStall);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      checkOutput({tag, "_stall"}, {31'd0, stall}, {31'd0, expStall});
      tick();
      n++;
    end
    checkOutput({tag, "_len"}, n, expN);
    checkOutput({tag, "_stall_end"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);

    // mult -2 * 3 with d_md held high
    applyStimulus(4'd1, 32'hFFFFFFFE, 32'd3, 1'b1);
    checkOutput("mult_issue_stall", {31'd0, stall}, 32'd1);
    tick();
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b1);
    waitBusy("mult", 5, 1'b1);
    checkOutput("mult_hi", hi, 32'hFFFFFFFF);
    checkOutput("mult_lo", lo, 32'hFFFFFFFA);

    // div -7 / 2 with d_md low
    applyStimulus(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    checkOutput("div_issue_stall", {31'd0, stall}, 32'd0);
    tick();
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
    waitBusy("div", 10, 1'b0);
    checkOutput("div_lo", lo, 32'hFFFFFFFD);
    checkOutput("div_hi", hi, 32'hFFFFFFFF);

    // signed overflow case
    applyStimulus(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    tick();
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
    waitBusy("divovf", 10, 1'b0);
    checkOutput("divovf_lo", lo, 32'h80000000);
    checkOutput("divovf_hi", hi, 32'd0);

    // mthi/mtlo never stall and land in one edge
    applyStimulus(4'd5, 32'h11, 32'd0, 1'b1);
    checkOutput("mthi_stall", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
    checkOutput("mthi_hi", hi, 32'h11);
    applyStimulus(4'd6, 32'h22, 32'd0, 1'b1);
    checkOutput("mtlo_stall", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("mtlo_lo", lo, 32'h22);

    // divu by zero keeps hi/lo
    applyStimulus(4'd4, 32'd5, 32'd0, 1'b0);
    tick();
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
    waitBusy("divz", 10, 1'b0);
    checkOutput("divz_hi", hi, 32'h11);
    checkOutput("divz_lo", lo, 32'h22);

    // multu max * max
    applyStimulus(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    tick();
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
    waitBusy("multu", 5, 1'b0);
    checkOutput("multu_hi", hi, 32'hFFFFFFFE);
    checkOutput("multu_lo", lo, 32'h00000001);

    // divu 100 / 7, then reset on its 3rd busy cycle
    applyStimulus(4'd4, 32'd100, 32'd7, 1'b0);
    tick();
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("rstmid_busy1", {31'd0, busy}, 32'd1);
    tick();
    tick();
    checkOutput("rstmid_busy3", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstmid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rstmid_hi", hi, 32'd0);
    checkOutput("rstmid_lo", lo, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    checkOutput("rstmid_late_hi", hi, 32'd0);
    checkOutput("rstmid_late_lo", lo, 32'd0);
    applyStimulus(4'd6, 32'd5, 32'd0, 1'b0);
    tick();
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("rstmid_mtlo", lo, 32'd5);

    // madd hi=0 lo=FFFFFFFF plus 1*1
    applyStimulus(4'd5, 32'd0, 32'd0, 1'b0);
    tick();
    applyStimulus(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
    tick();
    applyStimulus(4'd7, 32'd1, 32'd1, 1'b1);
`ifdef MD_MADD_EN
    checkOutput("madd_issue_stall", {31'd0, stall}, 32'd1);
    tick();
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b1);
    waitBusy("madd", 5, 1'b1);
    checkOutput("madd_hi", hi, 32'd1);
    checkOutput("madd_lo", lo, 32'd0);
`else
    checkOutput("madd_off_stall", {31'd0, stall}, 32'd0);
    tick();
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("madd_off_busy", {31'd0, busy}, 32'd0);
    checkOutput("madd_off_hi", hi, 32'd0);
    checkOutput("madd_off_lo", lo, 32'hFFFFFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide scheduler for the 5-stage pipeline.
- Owns the HI/LO registers and sequences mult/div operations issued from E stage over a fixed cycle count.
- Raises a stall request to the hazard/forwarding unit whenever a D-stage HI/LO-class instruction would collide with an in-flight or just-issued operation.
- Presents HI/LO read values for mfhi/mflo to the E-stage result mux.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (and madd family when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- op  in  4  E-stage HI/LO op, sampled every edge:
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo.
  - 7 madd, 8 maddu, 9 msub, 10 msubu (only with MD_MADD_EN).
  - 11-15 none.
- a  in  32  rs operand (forwarded value).
- b  in  32  rt operand (forwarded value).
- d_md  in  1  D-stage instruction is any HI/LO-class op (mult/div/mf/mt/madd family).
- busy  out  1  operation in flight.
- stall  out  1  stall request to the hazard unit.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset: state IDLE, cnt=0, busy=0, hi=0, lo=0. Reset wins over every other event, including mid-operation; an in-flight result is discarded.
- States:
  - IDLE, MUL, DIV.
  - cnt is a 4-bit down-counter.
  - Operand/op latches are internal.
- IDLE transitions:
  - op in {1,2,7..10 enabled}: latch a, b, op; cnt<=MUL_CYCLES; go to MUL.
  - op in {3,4}: latch a, b, op; cnt<=DIV_CYCLES; go to DIV.
  - op=5: hi<=a at that edge; stay IDLE; busy stays 0.
  - op=6: lo<=a at that edge; stay IDLE; busy stays 0.
- MUL/DIV:
  - busy=1.
  - cnt decrements each edge.
  - At the edge where cnt==1, write the result to {hi,lo}, clear busy, and return to IDLE.
  - busy is high exactly N cycles, where N is the parameter. The result is visible on hi/lo in the first cycle busy=0.
- Op arriving while busy:
  - Ignored.
  - The hazard unit guarantees this does not happen; the bench checks it never occurs under stall.
- Result arithmetic, computed from latched operands:
  - mult: {hi,lo} = signed(a)*signed(b), 64-bit.
  - multu: same product, unsigned.
  - div: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
  - div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - divu: unsigned quotient/remainder.
  - Divide by zero (b==0, signed or unsigned): hi/lo unchanged; the full DIV_CYCLES busy period still elapses.
- Stall:
  - Combinational: stall = d_md && (busy || op in start set {1,2,3,4, plus 7..10 if enabled}).
  - mthi/mtlo in E never cause a stall, since their write lands before the D instruction reaches E.
- hi/lo outputs are direct register outputs with no bypass. An mfhi issued the cycle after mthi reads the new value.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined: ops 7-10 start MUL-length operations:
  - madd: {hi,lo} += signed product.
  - maddu: {hi,lo} += unsigned product.
  - msub: {hi,lo} -= signed product.
  - msubu: {hi,lo} -= unsigned product.
  - Arithmetic is 64-bit modulo 2^64. The accumulate uses {hi,lo} as held at completion.
  - Ops 7-10 count toward stall.
- Undefined: ops 7-15 act as none. No state change, no stall contribution.

Test Plan:
- mult: rst, then op=1, a=0xFFFFFFFE, b=3 for one cycle.
  - Required: busy=1 for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- div: op=3, a=0xFFFFFFF9 (-7), b=2.
  - Required: busy for 10 cycles.
  - Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu by zero: preset hi=0x11, lo=0x22 via mthi/mtlo, then op=4, b=0.
  - Required: 10 busy cycles.
  - Then hi=0x11, lo=0x22.
- Stall: d_md=1 held while op=1 issues.
  - Required: stall=1 in the issue cycle and all 5 busy cycles; stall=0 the cycle busy drops.
  - With d_md=0: stall=0 throughout.
- Reset mid-op: rst on the 3rd busy cycle of a div.
  - Required: the next cycle shows busy=0, hi=lo=0, no late write.
  - A subsequent op=6, a=5 gives lo=5.
- MD_MADD_EN: hi=0, lo=0xFFFFFFFF, then op=7, a=1, b=1.
  - Required: after 5 cycles, hi=1, lo=0.
  - Without the macro: no busy, hi/lo unchanged.
